move_sequencer: RTL

- Front-end controller for the board update datapath. Accepts one move or undo command per handshake and expands it into one or two single-cycle update beats for the board updater.
- Castling adds a rook beat. En passant adds a victim-clear beat.
- Keeps a LIFO history of applied moves so undo replays beats reversed, and owns side-to-move (color_type).

---
 rtl/move_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// Expands move/undo commands into one or two board-update beats and keeps a LIFO move history.
// Optional HIST_OVERWRITE_EN turns the history into a ring buffer that overwrites the oldest move when full.
module move_sequencer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_undo,
  input  logic [5:0]       cmd_from,
  input  logic [5:0]       cmd_to,
  input  logic [5:0]       cmd_moving,
  input  logic [5:0]       cmd_captured,
  input  logic [2:0]       cmd_castling,
  input  logic [4:0]       cmd_enpassant,
  output logic             upd_enable,
  output logic [63:0]      upd_initialPosition,
  output logic [63:0]      upd_movedPosition,
  output logic [5:0]       upd_movingPiece,
  output logic [5:0]       upd_capturedPiece,
  output logic [2:0]       upd_castling,
  output logic [4:0]       upd_enpassant,
  output logic             upd_undo,
  output logic             color_type,
  output logic             busy,
  output logic [PTR_W:0]   hist_count,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B1   = 2'd1;
  localparam logic [1:0] S_B2   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

`ifdef HIST_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    logic [5:0] moving;
    logic [5:0] captured;
    logic [2:0] castling;
    logic [4:0] enpassant;
  } entry_t;

  typedef struct packed {
    logic [63:0] init;
    logic [63:0] moved;
    logic [5:0]  piece;
    logic [5:0]  cap;
  } beat_t;

  // The main beat moves the piece; the secondary beat moves the rook or clears/restores the
  // en passant victim. An undo runs the same beat with source and destination swapped.
  function automatic beat_t make_beat(input entry_t e, input logic side,
                                      input logic secondary, input logic undo);
    logic [5:0] base;
    logic [5:0] a;
    logic [5:0] b;
    beat_t      bt;
    base = side ? 6'd56 : 6'd0;
    bt   = '0;
    a    = '0;
    b    = '0;
    if (!secondary) begin
      a        = e.src;
      b        = e.dst;
      bt.piece = e.moving;
      bt.cap   = e.captured;
    end else if (e.castling != 3'b001) begin
      a        = e.castling[2] ? base + 6'd7 : base;
      b        = e.castling[2] ? base + 6'd5 : base + 6'd3;
      bt.piece = 6'b000010;
    end else begin
      a      = {e.src[5:3], e.dst[2:0]};
      b      = a;
      bt.cap = 6'b000001;
    end
    bt.init  = 64'd1 << (undo ? b : a);
    bt.moved = 64'd1 << (undo ? a : b);
    return bt;
  endfunction

  entry_t hist_q [DEPTH];

  logic [1:0]       state_q, state_d;
  entry_t           entry_q, entry_d;
  logic             undo_q, undo_d;
  logic             two_q, two_d;
  logic             side_q, side_d;
  logic             color_q, color_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             upd_en_q, upd_en_d;
  beat_t            beat_q, beat_d;
  logic [2:0]       upd_cas_q, upd_cas_d;
  logic [4:0]       upd_ep_q, upd_ep_d;
  logic             upd_undo_q, upd_undo_d;

  logic [PTR_W-1:0] top_idx;
  entry_t           cmd_entry;
  entry_t           sel_entry;
  logic             sel_two;
  logic             sel_side;
  logic             reject;

  always_comb begin
    top_idx   = top_q - PTR_W'(1);
    cmd_entry = '{src: cmd_from, dst: cmd_to, moving: cmd_moving, captured: cmd_captured,
                  castling: cmd_castling, enpassant: cmd_enpassant};
    sel_entry = cmd_undo ? hist_q[top_idx] : cmd_entry;
    sel_two   = (sel_entry.castling != 3'b001) || (sel_entry.enpassant != 5'b00001);
    // An undo replays the move of the side that is not currently to move.
    sel_side  = cmd_undo ? ~color_q : color_q;
    if (cmd_undo)
      reject = (count_q == '0);
    else
      reject = ((cmd_castling != 3'b001) && (cmd_enpassant != 5'b00001)) ||
               ((count_q == DEPTH_C) && !OVERWRITE);
  end

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    undo_d     = undo_q;
    two_d      = two_q;
    side_d     = side_q;
    color_d    = color_q;
    count_d    = count_q;
    top_d      = top_q;
    err_d      = 1'b0;
    upd_en_d   = 1'b0;
    beat_d     = '0;
    upd_cas_d  = '0;
    upd_ep_d   = '0;
    upd_undo_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_B1;
            entry_d    = sel_entry;
            undo_d     = cmd_undo;
            two_d      = sel_two;
            side_d     = sel_side;
            upd_en_d   = 1'b1;
            beat_d     = make_beat(sel_entry, sel_side, cmd_undo && sel_two, cmd_undo);
            upd_cas_d  = sel_entry.castling;
            upd_ep_d   = sel_entry.enpassant;
            upd_undo_d = cmd_undo;
          end
        end
      end
      S_B1: begin
        if (two_q) begin
          state_d    = S_B2;
          upd_en_d   = 1'b1;
          beat_d     = make_beat(entry_q, side_q, !undo_q, undo_q);
          upd_cas_d  = entry_q.castling;
          upd_ep_d   = entry_q.enpassant;
          upd_undo_d = undo_q;
        end else begin
          state_d = S_FIN;
        end
      end
      S_B2: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        color_d = ~color_q;
        if (undo_q) begin
          count_d = count_q - 1'b1;
          top_d   = top_q - 1'b1;
        end else begin
          top_d = top_q + 1'b1;
          if (count_q != DEPTH_C)
            count_d = count_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      undo_q     <= 1'b0;
      two_q      <= 1'b0;
      side_q     <= 1'b0;
      color_q    <= 1'b0;
      count_q    <= '0;
      top_q      <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      upd_en_q   <= 1'b0;
      beat_q     <= '0;
      upd_cas_q  <= '0;
      upd_ep_q   <= '0;
      upd_undo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      undo_q     <= undo_d;
      two_q      <= two_d;
      side_q     <= side_d;
      color_q    <= color_d;
      count_q    <= count_d;
      top_q      <= top_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      upd_en_q   <= upd_en_d;
      beat_q     <= beat_d;
      upd_cas_q  <= upd_cas_d;
      upd_ep_q   <= upd_ep_d;
      upd_undo_q <= upd_undo_d;
    end
  end

  // When full in ring mode, top_q already points at the oldest slot, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (!clear && (state_q == S_FIN) && !undo_q)
      hist_q[top_q] <= entry_q;
  end

  assign cmd_ready           = ready_q;
  assign upd_enable          = upd_en_q;
  assign upd_initialPosition = beat_q.init;
  assign upd_movedPosition   = beat_q.moved;
  assign upd_movingPiece     = beat_q.piece;
  assign upd_capturedPiece   = beat_q.cap;
  assign upd_castling        = upd_cas_q;
  assign upd_enpassant       = upd_ep_q;
  assign upd_undo            = upd_undo_q;
  assign color_type          = color_q;
  assign busy                = busy_q;
  assign hist_count          = count_q;
  assign err                 = err_q;

endmodule
